// File: rtl/result_uart_formatter_if.sv
// FIFO-pop and UART-send handshake bundle between the result FIFO, the formatter and the UART.
// The formatter uses master; the FIFO/UART side uses slave.
interface result_uart_formatter_if;
  logic        fifo_empty;
  logic        fifo_read;
  logic [55:0] fifo_data;
  logic        tx_ready;
  logic        tx_send;
  logic [7:0]  tx_data;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_read, tx_send, tx_data
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_read, tx_send, tx_data
  );
endinterface

// File: rtl/result_uart_formatter.sv
// Pops packed 8-char result records from the hash FIFO and streams them to the UART
// one byte at a time, terminated with CR LF.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a record in the FIFO while the UART is idle
// FETCH    | counting FIFO read latency, then latching the record
// SELECT   | picking the next char (or CR/LF); NUL chars may be skipped
// WAIT_RDY | holding tx_data until the UART reports ready, then send
// GAP      | one-cycle pause that lets the UART drop tx_ready
module result_uart_formatter #(
  parameter int FIFO_LATENCY = 1,
  parameter int SKIP_NUL     = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    fpgaclk,
  input  logic                    reset,
  result_uart_formatter_if.master bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        records_sent
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SELECT,
    WAIT_RDY,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [1:0]      lat_q, lat_d;
  logic [7:0][6:0] rec_q, rec_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            fifo_read_c;
  logic            tx_send_c;
  logic [6:0]      char_sel;

  assign char_sel = rec_q[idx_q[2:0]];

  always_ff @(posedge fpgaclk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lat_q     <= '0;
      rec_q     <= '0;
      tx_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lat_q     <= lat_d;
      rec_q     <= rec_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    rec_d       = rec_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    fifo_read_c = 1'b0;
    tx_send_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty && bus.tx_ready) begin
          fifo_read_c = 1'b1;
          lat_d       = 2'd1;
          state_d     = FETCH;
        end
      end

      FETCH: begin
        // fifo_empty is deliberately not looked at here: the pop already happened
        if (lat_q == 2'(FIFO_LATENCY)) begin
          rec_d   = bus.fifo_data;
          idx_d   = '0;
          state_d = SELECT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      SELECT: begin
        if (idx_q == 4'd8) begin
          tx_data_d = 8'h0D;
          state_d   = WAIT_RDY;
        end else if (idx_q == 4'd9) begin
          tx_data_d = 8'h0A;
          state_d   = WAIT_RDY;
        end else if ((SKIP_NUL != 0) && (char_sel == 7'd0)) begin
          idx_d = idx_q + 4'd1;
        end else begin
          tx_data_d = {1'b0, char_sel};
          state_d   = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (bus.tx_ready) begin
          tx_send_c = 1'b1;
          state_d   = GAP;
        end
      end

      GAP: begin
        if (idx_q == 4'd9) begin
          idx_d   = '0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = SELECT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by reset so an abort kills them without waiting for a clock
  assign bus.fifo_read = fifo_read_c & ~reset;
  assign bus.tx_send   = tx_send_c & ~reset;
  assign bus.tx_data   = tx_data_q;
  assign busy          = (state_q != IDLE);
  assign records_sent  = cnt_q;

  a_no_double_send : assert property (@(posedge fpgaclk) disable iff (reset)
    bus.tx_send |=> !bus.tx_send);

  a_no_pop_while_busy : assert property (@(posedge fpgaclk) disable iff (reset)
    bus.fifo_read |-> !busy);

endmodule

// File: tb/tb_result_uart_formatter.sv
// Bench for result_uart_formatter: two instances (defaults, and SKIP_NUL=0/FIFO_LATENCY=3/CNT_W=2)
// against a FIFO + UART model and a char-list reference of each record.
module tb_result_uart_formatter;
  logic fpgaclk = 1'b0;
  logic reset   = 1'b1;
  always #5 fpgaclk = ~fpgaclk;

  int checks = 0;
  int errors = 0;

  logic [1:0]        fifo_empty_v;
  logic [1:0]        fifo_read_v;
  logic [1:0][55:0]  fifo_data_v;
  logic [1:0]        tx_ready_v = 2'b11;
  logic [1:0]        tx_send_v;
  logic [1:0][7:0]   tx_data_v;
  logic [1:0]        busy_v;
  logic [1:0][15:0]  rs_v;

  logic [55:0] fmem [2][64];
  int          f_wr [2] = '{0, 0};
  int          f_rd [2] = '{0, 0};
  int          hold_len [2] = '{0, 0};
  logic [7:0]  cap [2][1024];
  int          cap_n [2] = '{0, 0};
  int          fr_cnt [2] = '{0, 0};
  int          viol [2] = '{0, 0};
  logic [55:0] pend [2];
  int          fcnt [2] = '{0, 0};
  int          hcnt [2] = '{0, 0};
  logic [1:0]  prev_send = 2'b00;
  int          exp_rs [2] = '{0, 0};
  logic [7:0]  exp_q [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT  = (g == 1) ? 3 : 1;
    localparam int SKIP = (g == 1) ? 0 : 1;
    localparam int CW   = (g == 1) ? 2 : 16;
    result_uart_formatter_if u_if();
    logic [CW-1:0] rs;
    assign u_if.fifo_empty = (f_wr[g] == f_rd[g]);
    assign u_if.fifo_data  = fifo_data_v[g];
    assign u_if.tx_ready   = tx_ready_v[g];
    assign fifo_empty_v[g] = u_if.fifo_empty;
    assign fifo_read_v[g]  = u_if.fifo_read;
    assign tx_send_v[g]    = u_if.tx_send;
    assign tx_data_v[g]    = u_if.tx_data;
    assign rs_v[g]         = 16'(rs);
    result_uart_formatter #(.FIFO_LATENCY(LAT), .SKIP_NUL(SKIP), .CNT_W(CW)) u_dut (
      .fpgaclk      (fpgaclk),
      .reset        (reset),
      .bus          (u_if.master),
      .busy         (busy_v[g]),
      .records_sent (rs)
    );
  end

  function automatic int lat_of(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  function automatic logic [55:0] rnd56();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[55:0];
  endfunction

  function automatic logic [55:0] rnd_rec(input bit allow_nul);
    logic [55:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (allow_nul && $urandom_range(0, 2) == 0) r[7*k +: 7] = 7'd0;
      else r[7*k +: 7] = 7'($urandom_range(1, 127));
    end
    return r;
  endfunction

  // Reference: every char in order (NULs dropped when skipping), then CR LF
  function automatic void add_exp(input logic [55:0] rec, input bit skip);
    logic [6:0] c;
    for (int k = 0; k < 8; k++) begin
      c = rec[7*k +: 7];
      if (!(skip && c == 7'd0)) exp_q.push_back({1'b0, c});
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // FIFO with configurable read latency (garbage on fifo_data except in the valid cycle) and UART model
  always @(posedge fpgaclk) begin
    for (int g = 0; g < 2; g++) begin
      if (fifo_read_v[g]) begin
        pend[g]        <= fmem[g][f_rd[g] % 64];
        f_rd[g]        <= f_rd[g] + 1;
        fr_cnt[g]      <= fr_cnt[g] + 1;
        fcnt[g]        <= 1;
        fifo_data_v[g] <= (lat_of(g) == 1) ? fmem[g][f_rd[g] % 64] : rnd56();
        if (busy_v[g]) viol[g] <= viol[g] + 1;
      end else if (fcnt[g] != 0 && fcnt[g] < lat_of(g)) begin
        fcnt[g]        <= fcnt[g] + 1;
        fifo_data_v[g] <= (fcnt[g] + 1 == lat_of(g)) ? pend[g] : rnd56();
      end else begin
        fcnt[g]        <= 0;
        fifo_data_v[g] <= rnd56();
      end

      if (tx_send_v[g]) begin
        cap[g][cap_n[g] % 1024] <= tx_data_v[g];
        cap_n[g] <= cap_n[g] + 1;
        if (!tx_ready_v[g] || prev_send[g]) viol[g] <= viol[g] + 1;
        if (hold_len[g] > 0) begin
          tx_ready_v[g] <= 1'b0;
          hcnt[g]       <= hold_len[g];
        end
      end else if (hcnt[g] == 1) begin
        hcnt[g]       <= 0;
        tx_ready_v[g] <= 1'b1;
      end else if (hcnt[g] > 1) begin
        hcnt[g] <= hcnt[g] - 1;
      end
      prev_send[g] <= tx_send_v[g];
    end
  end

  task automatic push_rec(input int g, input logic [55:0] rec);
    fmem[g][f_wr[g] % 64] = rec;
    f_wr[g] = f_wr[g] + 1;
  endtask

  task automatic wait_done(input int g, input int budget);
    int n;
    n = 0;
    @(negedge fpgaclk);
    while (!(fifo_empty_v[g] && !busy_v[g] && !fifo_read_v[g]) && n < budget) begin
      @(negedge fpgaclk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_done[%0d]: still busy after %0d cycles, required idle", g, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge fpgaclk);
    @(negedge fpgaclk);
    for (int g = 0; g < 2; g++) begin
      checks++; if (fifo_read_v[g] !== 1'b0) begin errors++; $display("FAIL reset_fifo_read[%0d]: got %b want 0", g, fifo_read_v[g]); end
      checks++; if (tx_send_v[g] !== 1'b0) begin errors++; $display("FAIL reset_tx_send[%0d]: got %b want 0", g, tx_send_v[g]); end
      checks++; if (tx_data_v[g] !== 8'h00) begin errors++; $display("FAIL reset_tx_data[%0d]: got %h want 00", g, tx_data_v[g]); end
      checks++; if (busy_v[g] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", g, busy_v[g]); end
      checks++; if (rs_v[g] !== 16'd0) begin errors++; $display("FAIL reset_records[%0d]: got %0d want 0", g, rs_v[g]); end
    end
    reset = 1'b0;
    exp_rs = '{0, 0};
    @(negedge fpgaclk);
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy_v[0]); end
  endtask

  task automatic test_basic();
    logic [7:0] tab [10] = '{8'h52, 8'h45, 8'h53, 8'h45, 8'h54, 8'h20, 8'h20, 8'h20, 8'h0D, 8'h0A};
    int base, fr0, n;
    bit found;
    base = cap_n[0];
    fr0  = fr_cnt[0];
    @(posedge fpgaclk); #1;
    push_rec(0, {7'd32, 7'd32, 7'd32, 7'd84, 7'd69, 7'd83, 7'd69, 7'd82});
    n = 0; found = 0;
    while (!found && n < 20) begin
      n++;
      @(negedge fpgaclk);
      if (tx_send_v[0]) found = 1;
      else @(posedge fpgaclk);
    end
    checks++;
    if (!found || n != 4) begin errors++; $display("FAIL basic_latency: got %0d cycles (found=%0d) want 4", n, found); end
    wait_done(0, 200);
    exp_rs[0]++;
    checks++;
    if (cap_n[0] - base != 10) begin errors++; $display("FAIL basic_count: got %0d bytes want 10", cap_n[0] - base); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap[0][(base + i) % 1024] !== tab[i]) begin
        errors++; $display("FAIL basic_byte[%0d]: got %h want %h", i, cap[0][(base + i) % 1024], tab[i]);
      end
    end
    checks++; if (rs_v[0] !== 16'd1) begin errors++; $display("FAIL basic_records: got %0d want 1", rs_v[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy_v[0]); end
    checks++; if (fr_cnt[0] - fr0 != 1) begin errors++; $display("FAIL basic_pops: got %0d want 1", fr_cnt[0] - fr0); end
  endtask

  task automatic test_skip_nul();
    logic [7:0] t_skip [4] = '{8'h61, 8'h62, 8'h0D, 8'h0A};
    logic [7:0] t_keep [10] = '{8'h61, 8'h00, 8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h0A};
    logic [55:0] rec;
    int base [2];
    base[0] = cap_n[0]; base[1] = cap_n[1];
    @(posedge fpgaclk); #1;
    push_rec(0, {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd98, 7'd0, 7'd97});
    push_rec(1, {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd98, 7'd0, 7'd97});
    wait_done(0, 200);
    wait_done(1, 200);
    exp_rs[0]++; exp_rs[1]++;
    checks++; if (cap_n[0] - base[0] != 4) begin errors++; $display("FAIL skip_count: got %0d want 4", cap_n[0] - base[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap[0][(base[0] + i) % 1024] !== t_skip[i]) begin errors++; $display("FAIL skip_byte[%0d]: got %h want %h", i, cap[0][(base[0] + i) % 1024], t_skip[i]); end
    end
    checks++; if (cap_n[1] - base[1] != 10) begin errors++; $display("FAIL keep_count: got %0d want 10", cap_n[1] - base[1]); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap[1][(base[1] + i) % 1024] !== t_keep[i]) begin errors++; $display("FAIL keep_byte[%0d]: got %h want %h", i, cap[1][(base[1] + i) % 1024], t_keep[i]); end
    end

    // an all-NUL record still yields CR LF and counts as sent
    base[0] = cap_n[0];
    @(posedge fpgaclk); #1;
    push_rec(0, 56'd0);
    wait_done(0, 200);
    exp_rs[0]++;
    checks++; if (cap_n[0] - base[0] != 2) begin errors++; $display("FAIL allnul_count: got %0d want 2", cap_n[0] - base[0]); end
    checks++;
    if (cap[0][base[0] % 1024] !== 8'h0D || cap[0][(base[0] + 1) % 1024] !== 8'h0A) begin
      errors++; $display("FAIL allnul_bytes: got %h %h want 0d 0a", cap[0][base[0] % 1024], cap[0][(base[0] + 1) % 1024]);
    end
    checks++; if (rs_v[0] !== 16'(exp_rs[0])) begin errors++; $display("FAIL allnul_records: got %0d want %0d", rs_v[0], exp_rs[0]); end

    for (int r = 0; r < 4; r++) begin
      rec = rnd_rec(1'b1);
      base[0] = cap_n[0]; base[1] = cap_n[1];
      @(posedge fpgaclk); #1;
      push_rec(0, rec);
      push_rec(1, rec);
      wait_done(0, 200);
      wait_done(1, 200);
      for (int g = 0; g < 2; g++) begin
        exp_q.delete();
        add_exp(rec, g == 0);
        exp_rs[g]++;
        checks++;
        if (cap_n[g] - base[g] != exp_q.size()) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", g, cap_n[g] - base[g], exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (cap[g][(base[g] + i) % 1024] !== exp_q[i]) begin errors++; $display("FAIL rand_byte[%0d][%0d]: got %h want %h", g, i, cap[g][(base[g] + i) % 1024], exp_q[i]); end
        end
        checks++;
        if (rs_v[g] !== 16'(exp_rs[g] % ((g == 1) ? 4 : 65536))) begin
          errors++; $display("FAIL rand_records[%0d]: got %0d want %0d", g, rs_v[g], exp_rs[g] % ((g == 1) ? 4 : 65536));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] recs [3];
    int base, fr0, v0;
    hold_len[0] = $urandom_range(40, 90);
    base = cap_n[0]; fr0 = fr_cnt[0]; v0 = viol[0];
    exp_q.delete();
    @(posedge fpgaclk); #1;
    for (int r = 0; r < 3; r++) begin
      recs[r] = rnd_rec(1'b0);
      push_rec(0, recs[r]);
      add_exp(recs[r], 1'b1);
    end
    wait_done(0, 5000);
    exp_rs[0] += 3;
    hold_len[0] = 0;
    checks++; if (cap_n[0] - base != 30) begin errors++; $display("FAIL b2b_count: got %0d want 30", cap_n[0] - base); end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (cap[0][(base + i) % 1024] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, cap[0][(base + i) % 1024], exp_q[i]); end
    end
    checks++; if (fr_cnt[0] - fr0 != 3) begin errors++; $display("FAIL b2b_pops: got %0d want 3", fr_cnt[0] - fr0); end
    checks++; if (viol[0] != v0) begin errors++; $display("FAIL b2b_handshake: got %0d violations want 0", viol[0] - v0); end
    checks++; if (rs_v[0] !== 16'(exp_rs[0])) begin errors++; $display("FAIL b2b_records: got %0d want %0d", rs_v[0], exp_rs[0]); end
    repeat (100) @(posedge fpgaclk);
  endtask

  task automatic test_reset_abort();
    logic [55:0] rec_a, rec_b;
    int base, n;
    bit hit;
    rec_a = rnd_rec(1'b0);
    rec_b = rnd_rec(1'b0);
    base = cap_n[0];
    @(posedge fpgaclk); #1;
    push_rec(0, rec_a);
    push_rec(0, rec_b);
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      @(negedge fpgaclk);
      n++;
      if (cap_n[0] - base == 4 && tx_send_v[0]) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach: got no 5th send request within %0d cycles, required one", n); end
    reset = 1'b1;
    #1;
    checks++; if (tx_send_v[0] !== 1'b0) begin errors++; $display("FAIL abort_tx_send: got %b want 0", tx_send_v[0]); end
    checks++; if (fifo_read_v[0] !== 1'b0) begin errors++; $display("FAIL abort_fifo_read: got %b want 0", fifo_read_v[0]); end
    checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_v[0]); end
    repeat (2) @(posedge fpgaclk);
    @(negedge fpgaclk);
    checks++; if (fifo_read_v[0] !== 1'b0) begin errors++; $display("FAIL abort_pop_in_reset: got %b want 0", fifo_read_v[0]); end
    checks++; if (cap_n[0] - base != 4) begin errors++; $display("FAIL abort_partial: got %0d bytes want 4", cap_n[0] - base); end
    reset = 1'b0;
    exp_rs = '{0, 0};
    base = cap_n[0];
    wait_done(0, 200);
    exp_rs[0]++;
    exp_q.delete();
    add_exp(rec_b, 1'b1);
    checks++; if (cap_n[0] - base != 10) begin errors++; $display("FAIL abort_next_count: got %0d want 10", cap_n[0] - base); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cap[0][(base + i) % 1024] !== exp_q[i]) begin errors++; $display("FAIL abort_next_byte[%0d]: got %h want %h", i, cap[0][(base + i) % 1024], exp_q[i]); end
    end
    checks++; if (rs_v[0] !== 16'd1) begin errors++; $display("FAIL abort_records: got %0d want 1", rs_v[0]); end
  endtask

  task automatic test_latency3();
    logic [55:0] rec;
    int base, n;
    bit found;
    for (int r = 0; r < 3; r++) begin
      rec = rnd_rec(1'b1);
      base = cap_n[1];
      @(posedge fpgaclk); #1;
      push_rec(1, rec);
      n = 0; found = 0;
      while (!found && n < 20) begin
        n++;
        @(negedge fpgaclk);
        if (tx_send_v[1]) found = 1;
        else @(posedge fpgaclk);
      end
      checks++;
      if (!found || n != 6) begin errors++; $display("FAIL lat3_latency: got %0d cycles (found=%0d) want 6", n, found); end
      wait_done(1, 200);
      exp_rs[1]++;
      exp_q.delete();
      add_exp(rec, 1'b0);
      checks++; if (cap_n[1] - base != 10) begin errors++; $display("FAIL lat3_count: got %0d want 10", cap_n[1] - base); end
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (cap[1][(base + i) % 1024] !== exp_q[i]) begin errors++; $display("FAIL lat3_byte[%0d]: got %h want %h", i, cap[1][(base + i) % 1024], exp_q[i]); end
      end
    end
  endtask

  task automatic test_wrap();
    int seq [5] = '{1, 2, 3, 0, 1};
    reset = 1'b1;
    repeat (2) @(posedge fpgaclk);
    @(negedge fpgaclk);
    reset = 1'b0;
    exp_rs = '{0, 0};
    for (int r = 0; r < 5; r++) begin
      @(posedge fpgaclk); #1;
      push_rec(1, rnd_rec(1'b1));
      wait_done(1, 200);
      checks++;
      if (rs_v[1] !== 16'(seq[r])) begin errors++; $display("FAIL wrap_records[%0d]: got %0d want %0d", r, rs_v[1], seq[r]); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_skip_nul();
    test_back_to_back();
    test_reset_abort();
    test_latency3();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_uart_formatter.md
Name: result_uart_formatter

Overview:
- Downstream of the hash controller's result FIFO. Pops 56-bit packed records (eight 7-bit ASCII chars) and serialises them byte by byte into the UART transmitter, then appends CR LF.
- Replaces the inline "continuously send FIFO queue" logic with a standalone block.
- Adds optional NUL-char skipping and a sent-record counter.

Parameters:
- FIFO_LATENCY, 1, cycles from fifo_read pulse to valid fifo_data (1..3).
- SKIP_NUL, 1, when 1, chars equal to 7'd0 are not transmitted.
- CNT_W, 16, width of records_sent counter.

Ports:
- fpgaclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- fifo_empty  in  1  result FIFO empty flag
- fifo_read  out  1  one-cycle pop strobe to FIFO
- fifo_data  in  56  packed record; char k = bits[7k+6:7k], k=0 sent first
- tx_ready  in  1  UART transmitter idle
- tx_send  out  1  one-cycle send strobe to UART
- tx_data  out  8  byte to UART, stable from tx_send until next tx_send
- busy  out  1  high from pop until LF handed to UART
- records_sent  out  CNT_W  count of completed records, wraps at 2^CNT_W

Behaviour:
- Reset: reset is asynchronous, active-high; clock fpgaclk. All outputs 0, state IDLE, char index 0, record register 0.
- States:
  - IDLE: if !fifo_empty && tx_ready, assert fifo_read for exactly one cycle, set busy=1, go to FETCH.
  - FETCH: wait FIFO_LATENCY cycles after the fifo_read cycle, latch fifo_data into the record register, idx=0, go to SELECT.
  - SELECT, idx 0..7: char = rec[7idx+6:7idx]. If SKIP_NUL && char==0, idx++ with no send (one cycle per skipped char). Otherwise tx_data={1'b0,char}, go to WAIT_RDY.
  - SELECT, idx 8: tx_data=8'h0D. idx 9: tx_data=8'h0A. Both go to WAIT_RDY.
  - WAIT_RDY: when tx_ready=1, pulse tx_send one cycle, go to GAP.
  - GAP: one cycle, tx_ready ignored to absorb the UART ready deassert latency. Then idx++. If idx was 9: records_sent++, busy=0, go to IDLE. Otherwise go to SELECT.
- Output rules:
  - tx_send is never high on two consecutive cycles.
  - fifo_read is never asserted while busy.
- Record with all chars NUL and SKIP_NUL=1: only CR LF sent; records_sent still increments.
- Minimum spacing between record pops: 1 idle cycle. The IDLE check happens only after returning to IDLE.
- fifo_empty rising during FETCH: ignored, the popped data is used.
- fifo_empty falling while busy: no effect until IDLE.
- Reset mid-record: immediate abort. The partial record is dropped and not retried. tx_send and fifo_read drop asynchronously.
- records_sent wraps from 2^CNT_W-1 to 0.
- Latency, FIFO non-empty with UART idle → first tx_send: 1 (pop) + FIFO_LATENCY + 1 (SELECT) + 1 (WAIT_RDY) cycles = 4 at default.

Test Plan:
- Reset, then push {7'd32,7'd32,7'd32,7'd84,7'd69,7'd83,7'd69,7'd82} with tx_ready always 1 → tx bytes 52 45 53 45 54 20 20 20 0D 0A; records_sent=1; busy low afterwards; first tx_send at cycle 4 after fifo_empty falls.
- SKIP_NUL=1, record with chars 'a',0,'b',0,0,0,0,0 → bytes 61 62 0D 0A only. Rerun with SKIP_NUL=0 → 61 00 62 00 00 00 00 00 0D 0A.
- UART model holding tx_ready low 868×10 cycles after each send, 3 queued records → 30 bytes in order; never two tx_send without an intervening ready-high; exactly 3 fifo_read pulses.
- Assert reset after the 4th byte of a record → tx_send/fifo_read/busy=0 immediately. After release, the next FIFO record is sent complete, and no remainder of the aborted record is sent.
- FIFO_LATENCY=3 with fifo_data changing every cycle after the pop → the value present exactly 3 cycles after the fifo_read cycle is transmitted.
- CNT_W=2, 5 records → records_sent sequence 1,2,3,0,1.
